// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared constants, FSM state type and the stall-merge
// helper used by the pipeline sequencer (pipeline_ctrl).
package pipeline_ctrl_pkg;

  localparam logic        Stop      = 1'b1;
  localparam logic        NoStop    = 1'b0;
  localparam logic [31:0] ZeroWord  = 32'h0;
  localparam logic [31:0] ExcVector = 32'hBFC00380;

  localparam logic [5:0] StallNone = 6'b000000;
  localparam logic [5:0] StallIf   = 6'b000011;
  localparam logic [5:0] StallId   = 6'b000111;
  localparam logic [5:0] StallEx   = 6'b001111;
  localparam logic [5:0] StallMem  = 6'b011111;

  typedef enum logic {
    CtrlRun     = 1'b0,
    CtrlWaitMem = 1'b1
  } ctrl_state_e;

  // Highest requesting stage wins; the result is always a contiguous
  // low-order run so the stopped stage's successor keeps draining.
  function automatic logic [5:0] merge_stall(
    input logic req_if,
    input logic req_id,
    input logic req_ex,
    input logic req_mem
  );
    logic [5:0] s;
    s = StallNone;
    priority case (1'b1)
      req_mem: s = StallMem;
      req_ex:  s = StallEx;
      req_id:  s = StallId;
      req_if:  s = StallIf;
      default: s = StallNone;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: merges per-stage stall requests and sequences the
// exception/ERET flush, deferring it while the MEM stage waits on the bus.
// Ports:
//   clk, resetn        clock, async active-low reset
//   i_stallreq_if/id/ex/mem  per-stage stall requests
//   i_except_valid, i_eret, i_epc  flush events and ERET target
//   o_stall[5:0]       bit0 PC .. bit5 WB, 1 = stop
//   o_flush, o_new_pc  one-cycle flush and its redirect target
//   o_perf_stall_cycles, o_perf_flush_count  counters, built only
//   when PIPELINE_CTRL_PERF_EN is defined (else tied to zero)
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_stallreq_if,
  input  logic        i_stallreq_id,
  input  logic        i_stallreq_ex,
  input  logic        i_stallreq_mem,
  input  logic        i_except_valid,
  input  logic        i_eret,
  input  logic [31:0] i_epc,
  output logic [5:0]  o_stall,
  output logic        o_flush,
  output logic [31:0] o_new_pc,
  output logic [31:0] o_perf_stall_cycles,
  output logic [31:0] o_perf_flush_count
);

  ctrl_state_e state_q, state_d;
  logic [31:0] pend_pc_q, pend_pc_d;

  logic        evt;
  logic [31:0] target;
  logic [5:0]  stall_d;
  logic        flush_d;
  logic [31:0] new_pc_d;

  assign evt    = i_except_valid | i_eret;
  // Exception outranks ERET when both arrive together.
  assign target = i_except_valid ? ExcVector : i_epc;

  always_comb begin
    state_d   = state_q;
    pend_pc_d = pend_pc_q;
    stall_d   = StallNone;
    flush_d   = 1'b0;
    new_pc_d  = ZeroWord;
    unique case (state_q)
      CtrlRun: begin
        if (evt && !i_stallreq_mem) begin
          flush_d  = 1'b1;
          new_pc_d = target;
        end else if (evt) begin
          stall_d   = StallMem;
          pend_pc_d = target;
          state_d   = CtrlWaitMem;
        end else begin
          stall_d = merge_stall(i_stallreq_if,
                                i_stallreq_id,
                                i_stallreq_ex,
                                i_stallreq_mem);
        end
      end
      CtrlWaitMem: begin
        // Only the bus wait matters here; other
        // requests and new events are dropped.
        if (i_stallreq_mem) begin
          stall_d = StallMem;
        end else begin
          flush_d  = 1'b1;
          new_pc_d = pend_pc_q;
          state_d  = CtrlRun;
        end
      end
      default: begin
        state_d = CtrlRun;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= CtrlRun;
      pend_pc_q <= ZeroWord;
    end else begin
      state_q   <= state_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  // Outputs stay combinational (same-cycle for id_exe) but are
  // forced quiet while reset is held.
  assign o_stall  = resetn ? stall_d  : StallNone;
  assign o_flush  = resetn ? flush_d  : 1'b0;
  assign o_new_pc = resetn ? new_pc_d : ZeroWord;

`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (o_stall != StallNone) stall_cnt_d = stall_cnt_q + 32'd1;
    if (o_flush)              flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_q <= ZeroWord;
      flush_cnt_q <= ZeroWord;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_perf_stall_cycles = stall_cnt_q;
  assign o_perf_flush_count  = flush_cnt_q;
`else
  assign o_perf_stall_cycles = ZeroWord;
  assign o_perf_flush_count  = ZeroWord;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed and random stimulus for pipeline_ctrl,
// checked against a behavioural model of the sequencer.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        rq_if, rq_id, rq_ex, rq_mem;
  logic        exc, eret;
  logic [31:0] epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] perf_st, perf_fl;

  int n_cmp = 0;
  int n_err = 0;

  // model state
  bit          m_pend;
  logic [31:0] m_ppc;
  logic [31:0] m_st_cnt, m_fl_cnt;

  pipeline_ctrl dut (
    .clk                 (clk),
    .resetn              (resetn),
    .i_stallreq_if       (rq_if),
    .i_stallreq_id       (rq_id),
    .i_stallreq_ex       (rq_ex),
    .i_stallreq_mem      (rq_mem),
    .i_except_valid      (exc),
    .i_eret              (eret),
    .i_epc               (epc),
    .o_stall             (stall),
    .o_flush             (flush),
    .o_new_pc            (new_pc),
    .o_perf_stall_cycles (perf_st),
    .o_perf_flush_count  (perf_fl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_perf(input string tag);
`ifdef PIPELINE_CTRL_PERF_EN
    chk({tag, "_pst"}, perf_st, m_st_cnt);
    chk({tag, "_pfl"}, perf_fl, m_fl_cnt);
`else
    chk({tag, "_pst"}, perf_st, 32'h0);
    chk({tag, "_pfl"}, perf_fl, 32'h0);
`endif
  endtask

  // Number of stopped stages: the highest requester plus all
  // earlier stages and the PC.
  function automatic logic [5:0] ref_stall(input bit a, b, c, d);
    int n;
    n = d ? 5 : c ? 4 : b ? 3 : a ? 2 : 0;
    return 6'((1 << n) - 1);
  endfunction

  // One cycle: drive, check outputs mid-cycle, advance model at edge.
  task automatic step(input string tag, input bit a, b, c, d,
                      input bit ex, er, input logic [31:0] pc);
    logic [5:0]  e_st;
    bit          e_fl;
    logic [31:0] e_pc;
    bit          n_pend;
    logic [31:0] n_ppc;
    rq_if = a; rq_id = b; rq_ex = c; rq_mem = d;
    exc = ex; eret = er; epc = pc;
    e_st = 6'd0; e_fl = 1'b0; e_pc = 32'h0;
    n_pend = m_pend; n_ppc = m_ppc;
    if (m_pend) begin
      if (d) e_st = 6'b011111;
      else begin
        e_fl = 1'b1; e_pc = m_ppc; n_pend = 1'b0;
      end
    end else if (ex || er) begin
      if (d) begin
        e_st = 6'b011111; n_pend = 1'b1;
        n_ppc = ex ? 32'hBFC00380 : pc;
      end else begin
        e_fl = 1'b1;
        e_pc = ex ? 32'hBFC00380 : pc;
      end
    end else begin
      e_st = ref_stall(a, b, c, d);
    end
    #2;
    chk({tag, "_stall"}, {26'd0, stall}, {26'd0, e_st});
    chk({tag, "_flush"}, {31'd0, flush}, {31'd0, e_fl});
    chk({tag, "_newpc"}, new_pc, e_pc);
    chk_perf(tag);
    @(posedge clk);
    m_pend = n_pend; m_ppc = n_ppc;
    if (e_st != 6'd0) m_st_cnt = m_st_cnt + 32'd1;
    if (e_fl)         m_fl_cnt = m_fl_cnt + 32'd1;
    #1;
  endtask

  // Pull reset for one cycle; inputs left as they were.
  task automatic do_reset(input string tag);
    resetn = 1'b0;
    #2;
    chk({tag, "_rst_stall"}, {26'd0, stall}, 32'h0);
    chk({tag, "_rst_flush"}, {31'd0, flush}, 32'h0);
    chk({tag, "_rst_newpc"}, new_pc, 32'h0);
    m_pend = 1'b0; m_ppc = 32'h0;
    m_st_cnt = 32'h0; m_fl_cnt = 32'h0;
    chk_perf(tag);
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    rq_if = 0; rq_id = 0; rq_ex = 0; rq_mem = 0;
    exc = 0; eret = 0; epc = 32'h0;
    m_pend = 0; m_ppc = 0; m_st_cnt = 0; m_fl_cnt = 0;
    @(posedge clk); #1;
    do_reset("init");

    // stall merge
    step("none",  0,0,0,0, 0,0, 32'h0);
    step("if",    1,0,0,0, 0,0, 32'h0);
    step("id",    0,1,0,0, 0,0, 32'h0);
    step("ex",    0,0,1,0, 0,0, 32'h0);
    step("mem",   0,0,0,1, 0,0, 32'h0);
    step("idex",  0,1,1,0, 0,0, 32'h0);
    step("all",   1,1,1,0, 0,0, 32'h0);

    // flushes in RUN, including back-to-back
    step("exc",   0,0,0,0, 1,0, 32'h0);
    step("after", 0,0,0,0, 0,0, 32'h0);
    step("eret",  0,0,0,0, 0,1, 32'h80001234);
    step("b2b1",  0,1,0,0, 1,1, 32'h80001234);
    step("b2b2",  0,0,1,0, 0,1, 32'h80005678);

    // exception under 3-cycle memory wait, epc toggling
    step("w0",    0,1,0,1, 1,0, 32'h11111111);
    step("w1",    0,1,0,1, 0,1, 32'h22222222);
    step("w2",    0,1,0,1, 1,0, 32'h33333333);
    step("wfl",   0,1,0,0, 0,0, 32'h44444444);
    step("wrun",  0,1,0,0, 0,0, 32'h44444444);

    // reset during WAIT_MEM with ERET pending
    step("r0",    0,0,0,1, 0,1, 32'h80000010);
    step("r1",    0,0,0,1, 0,0, 32'h80000010);
    do_reset("mid");
    rq_mem = 1'b0; eret = 1'b0;
    step("r2",    0,0,0,0, 0,0, 32'h80000010);
    step("r3",    0,0,0,0, 0,0, 32'h80000010);

    // counters: 5 stalled cycles, 2 flushes from a fresh reset
    do_reset("perf");
    step("p0", 1,0,0,0, 0,0, 32'h0);
    step("p1", 0,1,0,0, 0,0, 32'h0);
    step("p2", 0,0,1,0, 0,0, 32'h0);
    step("p3", 0,0,0,1, 0,0, 32'h0);
    step("p4", 1,1,0,0, 0,0, 32'h0);
    step("p5", 0,0,0,0, 1,0, 32'h0);
    step("p6", 0,0,0,0, 0,1, 32'h80000100);
    #2;
`ifdef PIPELINE_CTRL_PERF_EN
    chk("perf_st5", perf_st, 32'd5);
    chk("perf_fl2", perf_fl, 32'd2);
`else
    chk("perf_st0", perf_st, 32'd0);
    chk("perf_fl0", perf_fl, 32'd0);
`endif
    #1;

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) do_reset("rnd");
      step("rnd",
           1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 5) == 0),
           $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central pipeline sequencer for the five-stage MIPS core. It merges per-stage stall requests into the 6-bit `stall` vector that every inter-stage register (pc_reg, if_id, id_exe, exe_mem, mem_wb) consumes. It also sequences the exception/ERET flush: it raises the single-cycle `flush` pulse and supplies the redirect PC. When an exception coincides with a memory-bus wait, it holds the redirect until the MEM stage is free.

## Interface
- No parameters. Exception vector constant `ExcVector` (32'hBFC00380) lives in global_define.vh.
- clk  in  1  core clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- i_stallreq_if  in  1  fetch not ready (icache miss / bus wait)
- i_stallreq_id  in  1  load-use hazard in decode
- i_stallreq_ex  in  1  multi-cycle mult/div busy
- i_stallreq_mem  in  1  data access not complete
- i_except_valid  in  1  MEM-stage instruction takes an exception (already prioritised upstream)
- i_eret  in  1  MEM-stage instruction is ERET
- i_epc  in  32  CP0 EPC value
- o_stall  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; `Stop`=1
- o_flush  out  1  one-cycle flush to all inter-stage registers
- o_new_pc  out  32  redirect target, valid only while o_flush=1
- o_perf_stall_cycles  out  32  cycles with o_stall≠0 (see Configuration)
- o_perf_flush_count  out  32  number of flush pulses (see Configuration)

## Operation
- Stall merge, highest stage wins:
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if → 6'b000011
  - none → 6'b000000
- The vector is always a contiguous low-order run of ones. A stage stops while its successor runs, which lets id_exe insert a bubble.
- Event = i_except_valid | i_eret. Target = ExcVector if i_except_valid, else i_epc. An exception outranks ERET if both are asserted.
- FSM with two states:
  - RUN: event with i_stallreq_mem=0 → o_flush=1, o_new_pc=target, o_stall=0 this cycle; stay in RUN.
  - RUN: event with i_stallreq_mem=1 → latch target into pend_pc, o_stall=6'b011111, o_flush=0; go to WAIT_MEM.
  - RUN: no event → merged stall vector, o_flush=0.
  - WAIT_MEM while i_stallreq_mem=1 → o_stall=6'b011111; all other requests and new events are ignored.
  - WAIT_MEM when i_stallreq_mem falls → o_flush=1, o_new_pc=pend_pc, o_stall=0; go to RUN.
- Flush dominates stall: o_flush=1 always implies o_stall=0.
- o_new_pc = 32'h0 whenever o_flush=0.
- Reset (resetn=0, at any time including mid-WAIT_MEM): state←RUN, pend_pc←0, counters←0. While resetn=0: o_stall=0, o_flush=0, o_new_pc=0.

## Timing
- Stall and flush outputs are combinational from the current inputs and state: zero-cycle latency. This is required so that id_exe sees stall and flush in the same cycle as the request.
- Flush pulse is exactly one cycle per event. Back-to-back events in consecutive RUN cycles each produce their own pulse.
- Minimum flush delay under a memory wait is 1 cycle after i_stallreq_mem deasserts (N-cycle wait gives the flush on cycle N+1 relative to the event).
- pend_pc is captured on the rising edge that leaves RUN. It is stable throughout WAIT_MEM even if i_epc changes.
- Counters update on the rising edge and wrap modulo 2^32.

## Configuration
- `PIPELINE_CTRL_PERF_EN` defined:
  - o_perf_stall_cycles increments every cycle with o_stall≠0.
  - o_perf_flush_count increments every cycle with o_flush=1.
- Macro undefined: both ports remain present and are tied to 32'h0; no counter flops are built.

## Structure
- `Stop`, `NoStop`, `ZeroWord` and `ExcVector` belong in global_define.vh, along with the state encodings `CtrlRun` (1'b0) and `CtrlWaitMem` (1'b1).
- A single flat module. The stall-merge priority logic is a natural small function inside it; no sub-module is needed.

## Test plan
- Requests only, one at a time: if → 000011, id → 000111, ex → 001111, mem → 011111. id+ex together → 001111. No request → 000000.
- Exception in RUN with no mem stall: one-cycle o_flush=1, o_new_pc=32'hBFC00380, o_stall=0. The next cycle has o_flush=0.
- ERET with i_epc=32'h80001234 in RUN: flush pulse with o_new_pc=32'h80001234.
- Exception while i_stallreq_mem=1 for 3 cycles, with i_epc toggling and i_stallreq_id=1 throughout:
  - o_stall=011111 for 3 cycles with no flush.
  - Then one flush pulse with o_new_pc=32'hBFC00380, then back to RUN.
- resetn pulled low mid-WAIT_MEM (ERET pending, i_epc=32'h80000010), released with i_stallreq_mem=0: no flush is ever issued and all outputs are 0 during reset.
- With PIPELINE_CTRL_PERF_EN: 5 stalled cycles and 2 flushes → o_perf_stall_cycles=5, o_perf_flush_count=2. Without the macro, both read 0.
